// File: rtl/microseq_addr_unit.sv
// Control-state address register of a microsequencer: picks the next state from encoder/zero/pipeline/incrementer/past state.
// Latency: one edge; the selected source appears on State the cycle after the edge. Inc_addr is combinational.
// Backpressure: Adv=0 freezes everything; an encoder select without Enc_valid stalls, counts, and flags Timeout at STALL_MAX.
//
// Ports:
//   Clk, Reset            rising-edge clock, synchronous active-high reset
//   M                     next-address source select (000 enc, 001 zero, 010 pipe, 011 inc, 100 past; 101-111 illegal)
//   Enc_addr, Enc_valid   instruction-encoder target state and its valid
//   Pipe_addr             CR field of the microinstruction pipeline register
//   Adv                   advance enable
//   State, Past_state     current state and the state before the most recent load
//   Inc_addr              State+1 (wraps)
//   Stalled, Timeout      waiting on the encoder; sticky stall-timeout flag
//   Sel_err               sticky illegal-select flag
module microseq_addr_unit #(
    parameter int AW        = 8,
    parameter int STALL_MAX = 15
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [2:0]    M,
    input  logic [AW-1:0] Enc_addr,
    input  logic          Enc_valid,
    input  logic [AW-1:0] Pipe_addr,
    input  logic          Adv,
    output logic [AW-1:0] State,
    output logic [AW-1:0] Past_state,
    output logic [AW-1:0] Inc_addr,
    output logic          Stalled,
    output logic          Timeout,
    output logic          Sel_err
);

    localparam logic [2:0] SEL_ENC  = 3'b000;
    localparam logic [2:0] SEL_ZERO = 3'b001;
    localparam logic [2:0] SEL_PIPE = 3'b010;
    localparam logic [2:0] SEL_INC  = 3'b011;
    localparam logic [2:0] SEL_PAST = 3'b100;

    // STALL_MAX is limited to 1..15, so four bits always hold the count.
    localparam logic [3:0] STALL_LIM = 4'(STALL_MAX);

    logic [3:0]    stall_cnt;
    logic [3:0]    stall_cnt_nxt;
    logic [AW-1:0] next_addr;
    logic          load;
    logic          stall_req;
    logic          illegal;

    assign Inc_addr = State + AW'(1);

    always_comb begin
        next_addr = State;
        load      = 1'b0;
        illegal   = 1'b0;
        case (M)
            SEL_ENC: begin
                next_addr = Enc_addr;
                load      = Enc_valid;
            end
            SEL_ZERO: begin
                next_addr = '0;
                load      = 1'b1;
            end
            SEL_PIPE: begin
                next_addr = Pipe_addr;
                load      = 1'b1;
            end
            SEL_INC: begin
                next_addr = Inc_addr;
                load      = 1'b1;
            end
            // Swap with Past_state: repeated use ping-pongs between two states.
            SEL_PAST: begin
                next_addr = Past_state;
                load      = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign stall_req     = (M == SEL_ENC) && !Enc_valid;
    // Saturate at the limit rather than wrap.
    assign stall_cnt_nxt = (stall_cnt == STALL_LIM) ? stall_cnt : stall_cnt + 4'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            State      <= '0;
            Past_state <= '0;
            Stalled    <= 1'b0;
            stall_cnt  <= 4'd0;
            Timeout    <= 1'b0;
            Sel_err    <= 1'b0;
        end else if (Adv) begin
            if (load) begin
                State      <= next_addr;
                Past_state <= State;
            end
            if (stall_req) begin
                Stalled   <= 1'b1;
                stall_cnt <= stall_cnt_nxt;
                if (stall_cnt_nxt == STALL_LIM) begin
                    Timeout <= 1'b1;
                end
            end else begin
                // Any non-stalling edge (including an encoder load) ends the stall episode.
                Stalled   <= 1'b0;
                stall_cnt <= 4'd0;
            end
            if (illegal) begin
                Sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_microseq_addr_unit.sv
module tb_microseq_addr_unit;

    localparam int AW   = 8;
    localparam int SMAX = 15;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [2:0]    M;
    logic [AW-1:0] Enc_addr;
    logic          Enc_valid;
    logic [AW-1:0] Pipe_addr;
    logic          Adv;
    logic [AW-1:0] State;
    logic [AW-1:0] Past_state;
    logic [AW-1:0] Inc_addr;
    logic          Stalled;
    logic          Timeout;
    logic          Sel_err;

    always #5 Clk = ~Clk;

    microseq_addr_unit #(.AW(AW), .STALL_MAX(SMAX)) dut (
        .Clk(Clk), .Reset(Reset), .M(M), .Enc_addr(Enc_addr), .Enc_valid(Enc_valid),
        .Pipe_addr(Pipe_addr), .Adv(Adv), .State(State), .Past_state(Past_state),
        .Inc_addr(Inc_addr), .Stalled(Stalled), .Timeout(Timeout), .Sel_err(Sel_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: architectural registers only, updated from the selection rules.
    logic [7:0] m_st, m_pst;
    int         m_cnt;
    bit         m_stl, m_to, m_se;

    task automatic model_step(input logic r, input logic a, input logic [2:0] m,
                              input logic ev, input logic [7:0] ea, input logic [7:0] pa);
        logic [7:0] nxt;
        if (r) begin
            m_st = 0; m_pst = 0; m_cnt = 0; m_stl = 0; m_to = 0; m_se = 0;
        end else if (a) begin
            if (m == 3'd0 && !ev) begin
                m_stl = 1;
                if (m_cnt < SMAX) m_cnt = m_cnt + 1;
                if (m_cnt == SMAX) m_to = 1;
            end else begin
                m_stl = 0;
                m_cnt = 0;
                if (m > 3'd4) begin
                    m_se = 1;
                end else begin
                    case (m)
                        3'd0:    nxt = ea;
                        3'd1:    nxt = 8'h00;
                        3'd2:    nxt = pa;
                        3'd3:    nxt = m_st + 8'd1;
                        default: nxt = m_pst;
                    endcase
                    m_pst = m_st;
                    m_st  = nxt;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] es, input logic [7:0] ep,
                           input logic estl, input logic eto, input logic ese);
        logic [7:0] ei;
        ei = es + 8'd1;
        chk({tag, ".State"},      16'(State),      16'(es));
        chk({tag, ".Past_state"}, 16'(Past_state), 16'(ep));
        chk({tag, ".Inc_addr"},   16'(Inc_addr),   16'(ei));
        chk({tag, ".Stalled"},    16'(Stalled),    16'(estl));
        chk({tag, ".Timeout"},    16'(Timeout),    16'(eto));
        chk({tag, ".Sel_err"},    16'(Sel_err),    16'(ese));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic drive(input logic r, input logic a, input logic [2:0] m,
                         input logic ev, input logic [7:0] ea, input logic [7:0] pa);
        Reset = r; Adv = a; M = m; Enc_valid = ev; Enc_addr = ea; Pipe_addr = pa;
        @(posedge Clk);
        #1;
        model_step(r, a, m, ev, ea, pa);
    endtask

    typedef struct {
        logic       r, a;
        logic [2:0] m;
        logic       ev;
        logic [7:0] ea, pa;
        logic [7:0] es, ep;
        logic       estl, eto, ese;
    } vec_t;

    function automatic vec_t mk(logic r, logic a, logic [2:0] m, logic ev, logic [7:0] ea,
                                logic [7:0] pa, logic [7:0] es, logic [7:0] ep,
                                logic estl, logic eto, logic ese);
        vec_t v;
        v.r = r; v.a = a; v.m = m; v.ev = ev; v.ea = ea; v.pa = pa;
        v.es = es; v.ep = ep; v.estl = estl; v.eto = eto; v.ese = ese;
        return v;
    endfunction

    vec_t vecs[26];

    initial begin
        Reset = 1'b1; Adv = 1'b0; M = 3'd0; Enc_valid = 1'b0; Enc_addr = 8'h00; Pipe_addr = 8'h00;

        //           r  a  m     ev ea     pa     State  Past   stl eto ese
        vecs[0]  = mk(1, 1, 3'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 1, 3'd3, 0, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        vecs[2]  = mk(0, 1, 3'd3, 0, 8'h00, 8'h00, 8'h02, 8'h01, 0, 0, 0);
        vecs[3]  = mk(0, 1, 3'd3, 0, 8'h00, 8'h00, 8'h03, 8'h02, 0, 0, 0);
        vecs[4]  = mk(0, 0, 3'd2, 0, 8'h00, 8'h77, 8'h03, 8'h02, 0, 0, 0);
        vecs[5]  = mk(0, 1, 3'd2, 0, 8'h00, 8'hFF, 8'hFF, 8'h03, 0, 0, 0);
        vecs[6]  = mk(0, 1, 3'd3, 0, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0, 0);
        vecs[7]  = mk(0, 1, 3'd2, 0, 8'h00, 8'h0A, 8'h0A, 8'h00, 0, 0, 0);
        vecs[8]  = mk(0, 1, 3'd2, 0, 8'h00, 8'h10, 8'h10, 8'h0A, 0, 0, 0);
        vecs[9]  = mk(0, 1, 3'd4, 0, 8'h00, 8'h00, 8'h0A, 8'h10, 0, 0, 0);
        vecs[10] = mk(0, 1, 3'd4, 0, 8'h00, 8'h00, 8'h10, 8'h0A, 0, 0, 0);
        vecs[11] = mk(0, 1, 3'd1, 0, 8'h00, 8'h55, 8'h00, 8'h10, 0, 0, 0);
        vecs[12] = mk(0, 1, 3'd2, 0, 8'h00, 8'h05, 8'h05, 8'h00, 0, 0, 0);
        vecs[13] = mk(0, 1, 3'd6, 0, 8'h00, 8'h99, 8'h05, 8'h00, 0, 0, 1);
        vecs[14] = mk(0, 1, 3'd2, 0, 8'h00, 8'h20, 8'h20, 8'h05, 0, 0, 1);
        vecs[15] = mk(0, 1, 3'd0, 1, 8'h33, 8'h00, 8'h33, 8'h20, 0, 0, 1);
        vecs[16] = mk(0, 1, 3'd5, 1, 8'h44, 8'h66, 8'h33, 8'h20, 0, 0, 1);
        vecs[17] = mk(1, 0, 3'd7, 1, 8'h44, 8'h66, 8'h00, 8'h00, 0, 0, 0);
        vecs[18] = mk(0, 1, 3'd0, 0, 8'hAB, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        vecs[19] = mk(0, 0, 3'd3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        vecs[20] = mk(0, 1, 3'd3, 0, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        vecs[21] = mk(0, 1, 3'd7, 0, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 1);
        vecs[22] = mk(1, 1, 3'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        vecs[23] = mk(0, 1, 3'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        vecs[24] = mk(0, 1, 3'd7, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        vecs[25] = mk(1, 1, 3'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);

        @(posedge Clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].r, vecs[i].a, vecs[i].m, vecs[i].ev, vecs[i].ea, vecs[i].pa);
            chk_all($sformatf("vec%0d", i), vecs[i].es, vecs[i].ep, vecs[i].estl, vecs[i].eto, vecs[i].ese);
        end

        // Encoder stall up to the timeout, then a late encoder load.
        for (int i = 0; i < SMAX; i++) begin
            drive(0, 1, 3'd0, 0, 8'h42, 8'h00);
            chk_all($sformatf("stall%0d", i), 8'h00, 8'h00, 1'b1, (i == SMAX - 1), 1'b0);
        end
        drive(0, 1, 3'd0, 1, 8'h42, 8'h00);
        chk_all("enc_late", 8'h42, 8'h00, 1'b0, 1'b1, 1'b0);

        // Timeout survives a fresh stall; reset mid-stall clears everything.
        drive(0, 1, 3'd0, 0, 8'h11, 8'h00);
        chk_all("restall", 8'h42, 8'h00, 1'b1, 1'b1, 1'b0);
        drive(1, 1, 3'd0, 0, 8'h11, 8'h00);
        chk_all("rst_stall", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Stall that reaches the limit exactly on the edge where reset is asserted.
        for (int i = 0; i < SMAX - 1; i++) drive(0, 1, 3'd0, 0, 8'h00, 8'h00);
        drive(1, 1, 3'd0, 0, 8'h00, 8'h00);
        chk_all("rst_to_edge", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized run against the model; alternate blocks favour long encoder stalls.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       r, a, ev;
            logic [2:0] m;
            r = ($urandom_range(0, 499) == 0);
            a = ($urandom_range(0, 3) != 0);
            if (((cyc / 256) % 2) == 1) begin
                m  = ($urandom_range(0, 9) < 8) ? 3'd0 : 3'($urandom_range(0, 7));
                ev = ($urandom_range(0, 19) == 0);
            end else begin
                m  = 3'($urandom_range(0, 7));
                ev = ($urandom_range(0, 1) == 1);
            end
            drive(r, a, m, ev, 8'($urandom), 8'($urandom));
            chk_all($sformatf("rnd%0d", cyc), m_st, m_pst, m_stl, m_to, m_se);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
